// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Presents one nibble at a time to a shared decoder; double-buffered updates apply only at frame boundaries.
module ssd_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NDIG-1:0]       value,
  input  logic [NDIG-1:0]         blank,
  input  logic                    load,
  output logic                    pending,
  output logic [3:0]              nibble,
  output logic [NDIG-1:0]         an,
  output logic [$clog2(NDIG)-1:0] dig,
  output logic                    frame_start
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(NDIG);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NDIG - 1);

  logic [TW-1:0]      tick_reg, tick_next;
  logic [DW-1:0]      dig_reg, dig_next;
  logic [4*NDIG-1:0]  act_val_reg, act_val_next;
  logic [NDIG-1:0]    act_blk_reg, act_blk_next;
  logic [4*NDIG-1:0]  sh_val_reg, sh_val_next;
  logic [NDIG-1:0]    sh_blk_reg, sh_blk_next;
  logic               pending_reg, pending_next;
  logic               boundary;
  logic               in_guard;

  always_comb begin
    tick_next    = tick_reg;
    dig_next     = dig_reg;
    act_val_next = act_val_reg;
    act_blk_next = act_blk_reg;
    sh_val_next  = sh_val_reg;
    sh_blk_next  = sh_blk_reg;
    pending_next = pending_reg;
    boundary     = (tick_reg == TICK_LAST) && (dig_reg == DIG_LAST);

    if (tick_reg == TICK_LAST) begin
      tick_next = '0;
      dig_next  = (dig_reg == DIG_LAST) ? '0 : dig_reg + 1'b1;
    end else begin
      tick_next = tick_reg + 1'b1;
    end

    // A load landing exactly on the boundary bypasses the shadow wait entirely.
    if (load && boundary) begin
      act_val_next = value;
      act_blk_next = blank;
      sh_val_next  = value;
      sh_blk_next  = blank;
      pending_next = 1'b0;
    end else if (load) begin
      sh_val_next  = value;
      sh_blk_next  = blank;
      pending_next = 1'b1;
    end else if (boundary && pending_reg) begin
      act_val_next = sh_val_reg;
      act_blk_next = sh_blk_reg;
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg    <= '0;
      dig_reg     <= '0;
      act_val_reg <= '0;
      act_blk_reg <= '1;
      sh_val_reg  <= '0;
      sh_blk_reg  <= '1;
      pending_reg <= 1'b0;
    end else begin
      tick_reg    <= tick_next;
      dig_reg     <= dig_next;
      act_val_reg <= act_val_next;
      act_blk_reg <= act_blk_next;
      sh_val_reg  <= sh_val_next;
      sh_blk_reg  <= sh_blk_next;
      pending_reg <= pending_next;
    end
  end

  assign in_guard    = (tick_reg < GUARD_T);
  assign nibble      = rst ? 4'h0 : act_val_reg[{dig_reg, 2'b00} +: 4];
  assign frame_start = ~rst & (tick_reg == '0) & (dig_reg == '0);
  assign dig         = dig_reg;
  assign pending     = pending_reg;

  // Each enable compares against its own index, so at most one can ever be low.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_an
      assign an[gi] = rst | in_guard | act_blk_reg[gi] | (dig_reg != DW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized and directed bench for ssd_scan_ctrl (NDIG=4, DIV=8, GUARD=2).
// The reference model tracks cycles since reset and the two banks with plain arithmetic.
module tb_ssd_scan_ctrl;
  localparam int NDIG = 4, DIV = 8, GUARD = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic        pending;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [1:0]  dig;
  logic        frame_start;

  int checks = 0, errors = 0;
  int cnt = 0;
  logic [15:0] m_av = '0, m_sv = '0;
  logic [3:0]  m_ab = '1, m_sb = '1;
  logic        m_pend = 1'b0;

  ssd_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .value(value), .blank(blank), .load(load),
    .pending(pending), .nibble(nibble), .an(an), .dig(dig), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected {an, nibble, dig, frame_start, pending} from the model.
  function automatic logic [11:0] exp_vec();
    int tk, dg;
    logic [3:0] a, n;
    logic f;
    tk = cnt % DIV;
    dg = (cnt / DIV) % NDIG;
    if (rst) begin
      a = 4'hF; n = 4'h0; f = 1'b0;
    end else begin
      n = m_av[4*dg +: 4];
      a = (tk < GUARD || m_ab[dg]) ? 4'hF : ~(4'b0001 << dg);
      f = (tk == 0 && dg == 0);
    end
    return {a, n, 2'(dg), f, m_pend};
  endfunction

  function automatic logic [11:0] act_vec();
    return {an, nibble, dig, frame_start, pending};
  endfunction

  task automatic drive(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] b);
    rst = r; load = ld; value = v; blank = b;
    #1;
  endtask

  task automatic tick_clk();
    logic bnd;
    @(posedge clk);
    if (rst) begin
      cnt = 0; m_av = '0; m_ab = '1; m_sv = '0; m_sb = '1; m_pend = 1'b0;
    end else begin
      bnd = (cnt % FRAME) == FRAME - 1;
      if (load && bnd) begin
        m_av = value; m_ab = blank; m_sv = value; m_sb = blank; m_pend = 1'b0;
      end else if (load) begin
        m_sv = value; m_sb = blank; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_av = m_sv; m_ab = m_sb; m_pend = 1'b0;
      end
      cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle_to(input int p);
    while (cnt % FRAME != p) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_to cyc=%0d got=%h exp=%h", cnt, act_vec(), exp_vec());
      end
      tick_clk();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 16'hFFFF, 4'h0);
    tick_clk();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_hold got=%h exp=%h", act_vec(), exp_vec());
      end
      tick_clk();
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0);
    checks++;
    if ({frame_start, an, dig, pending, nibble} !== {1'b1, 4'hF, 2'd0, 1'b0, 4'h0}) begin
      errors++; $display("FAIL reset_release fs=%b an=%b dig=%0d pend=%b nib=%h", frame_start, an, dig, pending, nibble);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i <= 64; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (an !== 4'hF || nibble !== 4'h0 || dig !== 2'((i / DIV) % NDIG) || frame_start !== (i % FRAME == 0)) begin
        errors++; $display("FAIL idle_const cyc=%0d an=%b nib=%h dig=%0d fs=%b", i, an, nibble, dig, frame_start);
      end
      tick_clk();
    end
  endtask

  task automatic test_mid_load();
    int p, sl, tk;
    idle_to(5);
    drive(1'b0, 1'b1, 16'h4321, 4'h0);
    tick_clk();
    for (int i = 6; i < 64; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_load cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      if (i <= 31) begin
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending cyc=%0d pending=%b exp=1", i, pending); end
      end else begin
        p = i - 32; sl = p / DIV; tk = p % DIV;
        checks++;
        if (pending !== 1'b0 || nibble !== 4'(sl + 1) || an !== ((tk < GUARD) ? 4'hF : ~(4'b0001 << sl))) begin
          errors++; $display("FAIL mid_show cyc=%0d pend=%b nib=%h an=%b", i, pending, nibble, an);
        end
      end
      tick_clk();
    end
  endtask

  task automatic test_boundary_load();
    idle_to(31);
    drive(1'b0, 1'b1, 16'hBEEF, 4'h0);
    tick_clk();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL bnd_load tick=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (pending !== 1'b0 || nibble !== 4'hF || frame_start !== (i == 0) || an !== ((i < GUARD) ? 4'hF : 4'b1110)) begin
        errors++; $display("FAIL bnd_show tick=%0d pend=%b nib=%h fs=%b an=%b", i, pending, nibble, frame_start, an);
      end
      tick_clk();
    end
  endtask

  task automatic test_back_to_back();
    idle_to(3);
    drive(1'b0, 1'b1, 16'h1111, 4'h0);
    tick_clk();
    idle_to(10);
    drive(1'b0, 1'b1, 16'h2222, 4'h0);
    tick_clk();
    idle_to(0);
    for (int i = 0; i < FRAME; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (nibble !== 4'h2) begin errors++; $display("FAIL b2b_nibble cyc=%0d nib=%h exp=2", i, nibble); end
      tick_clk();
    end
  endtask

  task automatic test_blank();
    logic [15:0] v;
    int sl, tk;
    v = 16'($urandom);
    idle_to(20);
    drive(1'b0, 1'b1, v, 4'b0100);
    tick_clk();
    idle_to(0);
    for (int i = 0; i < FRAME; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      sl = i / DIV; tk = i % DIV;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL blank cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (nibble !== v[4*sl +: 4] || an !== ((tk < GUARD || sl == 2) ? 4'hF : ~(4'b0001 << sl))) begin
        errors++; $display("FAIL blank_show cyc=%0d nib=%h an=%b", i, nibble, an);
      end
      tick_clk();
    end
  endtask

  task automatic test_reset_mid();
    idle_to(13);
    drive(1'b0, 1'b1, 16'($urandom), 4'h0);
    tick_clk();
    drive(1'b1, 1'b0, 16'h0, 4'h0);
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL rst_mid_hold got=%h exp=%h", act_vec(), exp_vec());
    end
    tick_clk();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if (an !== 4'hF || (i == 0 && {dig, frame_start, pending} !== {2'd0, 1'b1, 1'b0})) begin
        errors++; $display("FAIL rst_mid_dark cyc=%0d an=%b dig=%0d fs=%b pend=%b", i, an, dig, frame_start, pending);
      end
      tick_clk();
    end
  endtask

  task automatic test_random();
    logic r, ld;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(199) == 0);
      ld = ($urandom_range(5) == 0);
      drive(r, ld, 16'($urandom), 4'($urandom));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL onehot cyc=%0d an=%b exp=at most one low", i, an);
      end
      tick_clk();
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_mid_load();
    test_boundary_load();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
